irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller between device IRQ sources (timer, UART, buttons)
//  and the CPU irq input. Latches IRQ events into a pending register and
//  applies a mask. Presents the highest-priority unmasked source to the CPU
//  with a req/ack/eoi handshake. Mask, pending and trigger-mode registers
//  are memory-mapped on the 16-bit data bus via a BUS decoder select.
// PARAMETERS
//  CPU_WIDTH   16  data bus width; registers occupy bits [IRQ_NUM-1:0], upper bits read 0
//  IRQ_NUM     8   number of IRQ sources (<= CPU_WIDTH)
//  ID_W        3   width of irq_id, clog2(IRQ_NUM)
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          asynchronous active-low reset
//  irq_in     in   IRQ_NUM    raw source lines, bit0 = timer, bit1 = uart, bit2 = buttom
//  sel        in   1          register window selected by bus decoder
//  addr       in   2          register offset: 0 MASK, 1 PEND, 2 MODE, 3 STATUS
//  we         in   1          write strobe (valid with sel)
//  wdata      in   CPU_WIDTH  write data
//  rdata      out  CPU_WIDTH  read data, combinational from sel/addr, 0 when !sel
//  irq_req    out  1          interrupt request to CPU
//  irq_id     out  ID_W       index of requested source, stable while irq_req=1
//  irq_ack    in   1          1-cycle pulse: CPU has taken the interrupt
//  irq_eoi    in   1          1-cycle pulse: CPU returned from handler
// BEHAVIOUR
//  Reset: mask=0, pend=0, mode=0 (all level), prev=0, state=IDLE, irq_req=0, irq_id=0.
//  Registers:
//   - MASK (RW): 1 = enabled.
//   - PEND (R, W1C).
//   - MODE (RW): 1 = edge, 0 = level.
//   - STATUS (R): {state[1:0], irq_id} in low bits.
//  Each edge:
//   - prev <= irq_in.
//   - Edge bit: set when irq_in & ~prev.
//   - Level bit: set when irq_in=1.
//   - Clear sources: W1C write to PEND, or irq_ack for bit irq_id.
//   - Set beats clear in the same cycle.
//   - A level source still high re-pends the next cycle.
//  active = pend & mask. Winner = lowest set index (bit0 highest priority).
//  FSM:
//   - IDLE: if |active, then irq_id <= winner, irq_req <= 1, go REQ.
//   - REQ, irq_ack=1: irq_req <= 0, clear pend[irq_id] (subject to set-wins),
//     go SERVICE.
//   - REQ, active[irq_id]=0 and no ack (masked or W1C'd): irq_req <= 0, go IDLE
//     (request withdrawn).
//   - SERVICE: no nesting; pending events accumulate. irq_eoi=1 -> IDLE.
//     Next request is raised at the earliest 1 cycle later.
//  Corner cases:
//   - irq_id does not change in REQ, even if a higher-priority source pends.
//     Priority is re-evaluated only in IDLE.
//   - irq_ack outside REQ and irq_eoi outside SERVICE are ignored.
//  Latency: source rise sampled at edge k -> pend set at k -> irq_req=1 after
//  edge k+1.
//  Register writes take effect at the next edge. A MASK write in REQ can
//  withdraw the request that cycle.
//  Reset asserted mid-handshake clears all state immediately (async).
//  irq_req is low while rst_n=0.
// TESTING
//  1. Reset: with rst_n=0 -> rdata(all regs)=0, irq_req=0, irq_id=0.
//  2. MASK=0x0001, MODE=0x0001; pulse irq_in[0] 1 cycle -> irq_req=1 two edges
//     later with irq_id=0. Ack -> PEND=0, STATUS shows SERVICE; eoi -> IDLE.
//  3. MASK=0x00FF; raise irq_in[2] and irq_in[1] in the same cycle -> irq_id=1
//     first. After ack+eoi, irq_id=2 is requested.
//  4. Level mode, MASK=0x0002; hold irq_in[1]=1 through ack -> PEND bit1 re-sets.
//     Drop the source and write PEND=0x0002 -> PEND=0, no further irq_req after eoi.
//  5. In REQ, write MASK=0 -> irq_req falls next edge, state IDLE, PEND still 0x0001.
//     Rewrite MASK=0x0001 -> re-requested.
//  6. Assert rst_n=0 during SERVICE -> irq_req=0, PEND=0 immediately.
//     Release -> stays IDLE with no request.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source events into PEND, masks them, and hands the
// highest-priority (lowest index) enabled source to the CPU with a req/ack/eoi handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no request outstanding; priority is evaluated here only
// ST_REQ     | irq_req high, irq_id frozen, waiting for irq_ack
// ST_SERVICE | CPU is in the handler; new events pend until irq_eoi
module irq_ctrl #(
  parameter int CPU_WIDTH = 16,
  parameter int IRQ_NUM   = 8,
  parameter int ID_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_NUM-1:0]   irq_in,
  input  logic                 sel,
  input  logic [1:0]           addr,
  input  logic                 we,
  input  logic [CPU_WIDTH-1:0] wdata,
  output logic [CPU_WIDTH-1:0] rdata,
  output logic                 irq_req,
  output logic [ID_W-1:0]      irq_id,
  input  logic                 irq_ack,
  input  logic                 irq_eoi
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  state_t             state_q;
  logic               req_q;
  logic [ID_W-1:0]    id_q;

  logic [IRQ_NUM-1:0] mask_q, mask_d;
  logic [IRQ_NUM-1:0] pend_q, pend_d;
  logic [IRQ_NUM-1:0] mode_q, mode_d;
  logic [IRQ_NUM-1:0] prev_q;

  logic               wr_mask, wr_pend, wr_mode;
  logic [IRQ_NUM-1:0] set_v, ack_v, clr_v, active;
  logic [ID_W-1:0]    winner;
  logic               any_active;
  logic               keep_req;

  assign wr_mask = sel & we & (addr == ADDR_MASK);
  assign wr_pend = sel & we & (addr == ADDR_PEND);
  assign wr_mode = sel & we & (addr == ADDR_MODE);

  // Edge-mode sources pend on a rising edge only; level-mode sources pend while high.
  assign set_v = (irq_in & ~prev_q & mode_q) | (irq_in & ~mode_q);

  always_comb begin
    ack_v = '0;
    if (state_q == ST_REQ && irq_ack) begin
      ack_v[id_q] = 1'b1;
    end
  end

  assign clr_v  = ack_v | (wr_pend ? wdata[IRQ_NUM-1:0] : '0);
  assign pend_d = (pend_q & ~clr_v) | set_v;
  assign mask_d = wr_mask ? wdata[IRQ_NUM-1:0] : mask_q;
  assign mode_d = wr_mode ? wdata[IRQ_NUM-1:0] : mode_q;

  assign active     = pend_q & mask_q;
  assign any_active = |active;

  always_comb begin
    winner = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (active[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // Looks at next-cycle mask/pend so a MASK or W1C write withdraws the request on its own edge.
  assign keep_req = pend_d[id_q] & mask_d[id_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      pend_q <= '0;
      mode_q <= '0;
      prev_q <= '0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
      prev_q <= irq_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_active) begin
            id_q    <= winner;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            req_q   <= 1'b0;
            state_q <= ST_SERVICE;
          end else if (!keep_req) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (irq_eoi) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_req = req_q;
  assign irq_id  = id_q;

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        ADDR_MASK:   rdata[IRQ_NUM-1:0] = mask_q;
        ADDR_PEND:   rdata[IRQ_NUM-1:0] = pend_q;
        ADDR_MODE:   rdata[IRQ_NUM-1:0] = mode_q;
        ADDR_STATUS: rdata[ID_W+1:0]    = {state_q, id_q};
        default:     rdata              = '0;
      endcase
    end
  end

  generate
    if (CPU_WIDTH > IRQ_NUM) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^wdata[CPU_WIDTH-1:IRQ_NUM];
    end
  endgenerate

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed handshake scenarios followed by random traffic, all
// checked by a scoreboard fed from a bit-level reference model of the controller.
module tb_irq_ctrl;
  localparam int N = 8;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [N-1:0] irq_in  = '0;
  logic         sel     = 1'b0;
  logic [1:0]   addr    = 2'd0;
  logic         we      = 1'b0;
  logic [15:0]  wdata   = '0;
  logic         irq_ack = 1'b0;
  logic         irq_eoi = 1'b0;
  logic [15:0]  rdata;
  logic         irq_req;
  logic [2:0]   irq_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.CPU_WIDTH(16), .IRQ_NUM(N), .ID_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .sel     (sel),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .irq_ack (irq_ack),
    .irq_eoi (irq_eoi)
  );

  // Reference model: phase 0 = idle, 1 = requesting, 2 = in handler.
  bit [N-1:0] m_mask, m_pend, m_mode, m_prev;
  bit         m_req;
  int         m_id;
  int         m_ph;

  typedef struct {
    logic        req;
    logic [2:0]  id;
    logic [15:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_mode = '0; m_prev = '0;
    m_req = 1'b0; m_id = 0; m_ph = 0;
  endtask

  task automatic model_edge();
    bit [N-1:0] nmask, nmode, npend, act;
    if (!rst_n) begin
      model_reset();
    end else begin
      nmask = m_mask; nmode = m_mode; npend = m_pend;
      if (sel && we) begin
        for (int i = 0; i < N; i++) begin
          if (addr == 2'd0) nmask[i] = wdata[i];
          if (addr == 2'd1 && wdata[i]) npend[i] = 1'b0;
          if (addr == 2'd2) nmode[i] = wdata[i];
        end
      end
      if (m_ph == 1 && irq_ack) npend[m_id] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (irq_in[i] && (!m_mode[i] || !m_prev[i])) npend[i] = 1'b1;
      end
      act = m_pend & m_mask;
      if (m_ph == 0) begin
        if (act != 0) begin
          for (int i = N - 1; i >= 0; i--) if (act[i]) m_id = i;
          m_req = 1'b1;
          m_ph  = 1;
        end
      end else if (m_ph == 1) begin
        if (irq_ack) begin
          m_req = 1'b0; m_ph = 2;
        end else if (!(npend[m_id] && nmask[m_id])) begin
          m_req = 1'b0; m_ph = 0;
        end
      end else begin
        if (irq_eoi) m_ph = 0;
      end
      m_mask = nmask; m_mode = nmode; m_pend = npend; m_prev = irq_in;
    end
  endtask

  function automatic logic [15:0] m_rdata();
    if (!sel) return 16'h0000;
    case (addr)
      2'd0:    return {8'h00, m_mask};
      2'd1:    return {8'h00, m_pend};
      2'd2:    return {8'h00, m_mode};
      default: return 16'(m_ph * 8 + m_id);
    endcase
  endfunction

  // One cycle: record what the DUT must show this cycle, then let the edge happen.
  task automatic tick();
    exp_t e;
    if (!rst_n) model_reset();
    e.req   = m_req;
    e.id    = 3'(m_id);
    e.rdata = m_rdata();
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
    sel = 1'b0; we = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string nm);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(nm, rdata, exp);
    tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_irq_req", irq_req, e.req);
        chk("sb_irq_id", irq_id, e.id);
        chk("sb_rdata", rdata, e.rdata);
      end
    end
  end

  initial begin : stim
    model_reset();
    @(posedge clk);
    #1;
    // reset state
    rd(2'd0, 16'h0000, "rst_mask");
    rd(2'd1, 16'h0000, "rst_pend");
    rd(2'd2, 16'h0000, "rst_mode");
    rd(2'd3, 16'h0000, "rst_status");
    chk("rst_irq_req", irq_req, 1'b0);
    chk("rst_irq_id", irq_id, 3'd0);
    rst_n = 1'b1;

    // edge source 0, full handshake
    wr(2'd2, 16'h0001);
    wr(2'd0, 16'h0001);
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    chk("t2_req_early", irq_req, 1'b0);
    tick();
    chk("t2_req", irq_req, 1'b1);
    chk("t2_id", irq_id, 3'd0);
    irq_ack = 1'b1; tick();
    chk("t2_req_after_ack", irq_req, 1'b0);
    rd(2'd1, 16'h0000, "t2_pend");
    rd(2'd3, 16'h0010, "t2_status_service");
    irq_eoi = 1'b1; tick();
    rd(2'd3, 16'h0000, "t2_status_idle");

    // simultaneous sources: lowest index first
    wr(2'd0, 16'h00FF);
    irq_in = 8'h06; tick(); irq_in = 8'h00; tick();
    chk("t3_first_req", irq_req, 1'b1);
    chk("t3_first_id", irq_id, 3'd1);
    irq_ack = 1'b1; tick();
    irq_eoi = 1'b1; tick();
    tick();
    chk("t3_second_req", irq_req, 1'b1);
    chk("t3_second_id", irq_id, 3'd2);
    irq_ack = 1'b1; tick();
    irq_eoi = 1'b1; tick();

    // level source held through ack re-pends
    wr(2'd2, 16'h0000);
    wr(2'd0, 16'h0002);
    irq_in = 8'h02; tick(); tick();
    chk("t4_req", irq_req, 1'b1);
    chk("t4_id", irq_id, 3'd1);
    irq_ack = 1'b1; tick();
    rd(2'd1, 16'h0002, "t4_pend_repend");
    irq_in = 8'h00;
    wr(2'd1, 16'h0002);
    rd(2'd1, 16'h0000, "t4_pend_w1c");
    irq_eoi = 1'b1; tick();
    repeat (3) tick();
    chk("t4_no_req", irq_req, 1'b0);

    // mask write withdraws a request
    wr(2'd2, 16'h0001);
    wr(2'd0, 16'h0001);
    irq_in = 8'h01; tick(); irq_in = 8'h00; tick();
    chk("t5_req", irq_req, 1'b1);
    wr(2'd0, 16'h0000);
    chk("t5_withdrawn", irq_req, 1'b0);
    rd(2'd1, 16'h0001, "t5_pend_kept");
    rd(2'd3, 16'h0000, "t5_status_idle");
    wr(2'd0, 16'h0001);
    tick();
    chk("t5_rereq", irq_req, 1'b1);
    chk("t5_rereq_id", irq_id, 3'd0);
    irq_ack = 1'b1; tick();
    irq_eoi = 1'b1; tick();

    // async reset during the handler
    irq_in = 8'h01; tick(); irq_in = 8'h00; tick();
    irq_ack = 1'b1; tick();
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    rd(2'd1, 16'h0001, "t6_pend_before");
    rst_n = 1'b0; sel = 1'b1; addr = 2'd1;
    #1;
    chk("t6_req_in_reset", irq_req, 1'b0);
    chk("t6_pend_in_reset", rdata, 16'h0000);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_no_req", irq_req, 1'b0);
    rd(2'd3, 16'h0000, "t6_status");

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 8'($urandom);
      case ($urandom_range(0, 7))
        0: begin sel = 1'b1; we = 1'b1; addr = 2'($urandom); wdata = 16'($urandom); end
        1, 2: begin sel = 1'b1; addr = 2'($urandom); end
        default: ;
      endcase
      if (m_ph == 1) irq_ack = ($urandom_range(0, 2) == 0);
      else           irq_ack = ($urandom_range(0, 15) == 0);
      if (m_ph == 2) irq_eoi = ($urandom_range(0, 3) == 0);
      else           irq_eoi = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    tick();
    @(negedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
